// File: rtl/ifetch_prefetch.sv
// Prefetching instruction fetch unit: issues in-order imem requests into a DEPTH-entry
// queue, hands instructions to decode over valid/ready and re-targets on execute redirects.
module ifetch_prefetch #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [15:0] ex_imm,
  input  logic [25:0] ex_index,
  input  logic        Zero,
  input  logic [31:0] Read_Data_1,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Instruction,
  output logic [31:0] out_pc,
  output logic [31:0] branch_base_addr,
  output logic [31:0] link_addr,
  output logic        redirect
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];

  logic [31:0] seq_pc_s;
  logic [31:0] br_off_s;
  logic [31:0] target_s;
  logic [31:0] occupancy_s;
  logic [31:0] head_pc_s;
  logic        taken_br_s;
  logic        redirect_s;
  logic        req_valid_s;
  logic        accept_s;
  logic        head_valid_s;
  logic        deq_s;
  logic        enq_s;

  // Redirect decode: Jr beats Jmp/Jal, which beat a taken conditional branch.
  always_comb begin
    seq_pc_s   = ex_pc + 32'd4;
    br_off_s   = {{14{ex_imm[15]}}, ex_imm, 2'b00};
    taken_br_s = (Branch & Zero) | (nBranch & ~Zero);
    redirect_s = 1'b0;
    target_s   = 32'h0000_0000;
    if (ex_valid) begin
      if (Jr) begin
        redirect_s = 1'b1;
        target_s   = Read_Data_1;
      end else if (Jmp | Jal) begin
        redirect_s = 1'b1;
        target_s   = {seq_pc_s[31:28], ex_index, 2'b00};
      end else if (taken_br_s) begin
        redirect_s = 1'b1;
        target_s   = seq_pc_s + br_off_s;
      end else begin
        redirect_s = 1'b0;
        target_s   = 32'h0000_0000;
      end
    end else begin
      redirect_s = 1'b0;
      target_s   = 32'h0000_0000;
    end
  end

  // Request issue: a request is only made when its response is guaranteed a queue slot.
  always_comb begin
    occupancy_s  = 32'(count_q) + 32'(outstanding_q);
    req_valid_s  = Reset & ~redirect_s
                 & (32'(outstanding_q) < MAX_OUTSTANDING)
                 & (occupancy_s < DEPTH);
    accept_s     = req_valid_s & imem_req_ready;
    head_valid_s = (count_q != {CW{1'b0}});
    deq_s        = head_valid_s & ~redirect_s & out_ready;
  end

  // Next-state: redirect flushes the queue and marks every in-flight response for discard.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + OW'(accept_s) - OW'(imem_resp_valid);
    discard_d     = discard_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    data_d        = data_q;
    pc_d          = pc_q;
    enq_s         = 1'b0;
    if (redirect_s) begin
      fetch_pc_d = target_s;
      resp_pc_d  = target_s;
      discard_d  = outstanding_q - OW'(imem_resp_valid);
      count_d    = {CW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
    end else begin
      if (accept_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (imem_resp_valid) begin
        if (discard_q != {OW{1'b0}}) begin
          discard_d = discard_q - OW'(1'b1);
        end else begin
          enq_s            = 1'b1;
          data_d[wr_ptr_q] = imem_resp_data;
          pc_d[wr_ptr_q]   = resp_pc_q;
          wr_ptr_d         = wr_ptr_q + PW'(1'b1);
          resp_pc_d        = resp_pc_q + 32'd4;
        end
      end else begin
        enq_s = 1'b0;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(enq_s) - CW'(deq_s);
    end
  end

  // State registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= {OW{1'b0}};
      discard_q     <= {OW{1'b0}};
      count_q       <= {CW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= 32'h0000_0000;
        pc_q[i]   <= 32'h0000_0000;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      data_q        <= data_d;
      pc_q          <= pc_d;
    end
  end

  // Head fields read zero whenever the queue is empty.
  assign head_pc_s        = head_valid_s ? pc_q[rd_ptr_q] : 32'h0000_0000;
  assign imem_req_valid   = req_valid_s;
  assign imem_req_addr    = fetch_pc_q;
  assign redirect         = redirect_s;
  assign out_valid        = head_valid_s & ~redirect_s;
  assign Instruction      = head_valid_s ? data_q[rd_ptr_q] : 32'h0000_0000;
  assign out_pc           = head_pc_s;
  assign branch_base_addr = head_valid_s ? (head_pc_s + 32'd4) : 32'h0000_0000;
  assign link_addr        = head_valid_s ? (head_pc_s + 32'd4) : 32'h0000_0000;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: directed sequences, a redirect vector table and
// a randomized run checked against an instruction-stream model with an in-order memory.
module tb_ifetch_prefetch;

  localparam int MAXO = 2;
  localparam int DEPTH = 4;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk, rst_n;
  logic req_valid, req_ready, resp_valid;
  logic [31:0] req_addr, resp_data;
  logic ex_valid, zero, br, nbr, jmp, jal, jr;
  logic [31:0] ex_pc, rd1;
  logic [15:0] ex_imm;
  logic [25:0] ex_index;
  logic out_valid, out_ready, redirect;
  logic [31:0] instr, out_pc, bba, link;

  logic w_req_valid, w_resp_valid, w_out_valid, w_redirect;
  logic [31:0] w_req_addr, w_resp_data, w_instr, w_out_pc, w_bba, w_link;

  ifetch_prefetch u_dut (
    .Clock(clk), .Reset(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_index(ex_index),
    .Zero(zero), .Read_Data_1(rd1), .Branch(br), .nBranch(nbr), .Jmp(jmp), .Jal(jal), .Jr(jr),
    .out_valid(out_valid), .out_ready(out_ready), .Instruction(instr), .out_pc(out_pc),
    .branch_base_addr(bba), .link_addr(link), .redirect(redirect)
  );

  ifetch_prefetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .Clock(clk), .Reset(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .ex_valid(1'b0), .ex_pc(32'h0), .ex_imm(16'h0), .ex_index(26'h0),
    .Zero(1'b0), .Read_Data_1(32'h0), .Branch(1'b0), .nBranch(1'b0), .Jmp(1'b0), .Jal(1'b0), .Jr(1'b0),
    .out_valid(w_out_valid), .out_ready(1'b1), .Instruction(w_instr), .out_pc(w_out_pc),
    .branch_base_addr(w_bba), .link_addr(w_link), .redirect(w_redirect)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic        z;
    logic [31:0] r;
    logic        b, nb, j, jl, jrr;
    logic        exp_redir;
    logic [31:0] exp_target;
  } vec_t;

  int tests = 0, fails = 0;
  int cyc, lat, last_due, n_req, n_xfer;
  mreq_t memq[$];
  logic [31:0] wrap_pcs[$];
  logic [31:0] exp_pc, exp_req, xfer_pc, acc_addr, prev_addr, w_prev_addr;
  logic xfer_s, acc_s, redir_s, prev_stall, w_prev_acc;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Redirect rule straight from the ISA description: returns {taken, target}.
  function automatic logic [32:0] ref_redirect();
    logic [31:0] nxt, off;
    nxt = ex_pc + 32'd4;
    off = {{14{ex_imm[15]}}, ex_imm, 2'b00};
    if (!ex_valid) return 33'h0;
    if (jr) return {1'b1, rd1};
    if (jmp || jal) return {1'b1, nxt[31:28], ex_index, 2'b00};
    if ((br && zero) || (nbr && !zero)) return {1'b1, nxt + off};
    return 33'h0;
  endfunction

  task automatic clear_ex();
    ex_valid = 1'b0; ex_pc = 32'h0; ex_imm = 16'h0; ex_index = 26'h0; zero = 1'b0;
    rd1 = 32'h0; br = 1'b0; nbr = 1'b0; jmp = 1'b0; jal = 1'b0; jr = 1'b0;
  endtask

  // One clock cycle: drive memory responses, check the cycle, then advance past the edge.
  task automatic cycle();
    logic [32:0] rr;
    int sz0, due;
    sz0 = memq.size();
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    if (rst_n && memq.size() > 0 && memq[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = memq[0].addr ^ K;
      void'(memq.pop_front());
    end
    w_resp_valid = w_prev_acc;
    w_resp_data  = w_prev_addr ^ K;
    #1;
    rr = ref_redirect();
    redir_s = redirect;
    chk1("redirect", redirect, rr[32]);
    if (rr[32]) begin
      chk1("redir_no_req", req_valid, 1'b0);
      chk1("redir_no_out", out_valid, 1'b0);
    end
    if (prev_stall && req_valid) chk32("addr_stable", req_addr, prev_addr);
    acc_s = req_valid & req_ready;
    acc_addr = req_addr;
    if (acc_s) begin
      chk32("req_addr", req_addr, exp_req);
      chk1("outstanding_limit", sz0 < MAXO, 1'b1);
      exp_req = exp_req + 32'd4;
      n_req++;
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      memq.push_back('{addr: req_addr, due: due});
      last_due = due;
    end
    xfer_s = out_valid & out_ready;
    xfer_pc = out_pc;
    if (xfer_s) begin
      chk32("out_pc", out_pc, exp_pc);
      chk32("instr", instr, exp_pc ^ K);
      chk32("link_addr", link, exp_pc + 32'd4);
      chk32("branch_base", bba, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_xfer++;
    end
    if (rr[32]) begin
      exp_pc  = rr[31:0];
      exp_req = rr[31:0];
    end
    prev_stall = req_valid & ~req_ready;
    prev_addr  = req_addr;
    if (w_out_valid && wrap_pcs.size() < 3) wrap_pcs.push_back(w_out_pc);
    w_prev_acc  = w_req_valid;
    w_prev_addr = w_req_addr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    resp_valid = 1'b0; resp_data = 32'h0;
    w_resp_valid = 1'b0; w_resp_data = 32'h0;
    clear_ex();
    memq.delete();
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_req_valid", req_valid, 1'b0);
    chk1("rst_redirect", redirect, 1'b0);
    chk32("rst_instr", instr, 32'h0);
    chk32("rst_out_pc", out_pc, 32'h0);
    chk32("rst_link", link, 32'h0);
    chk32("rst_bba", bba, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0; exp_pc = 32'h0; exp_req = 32'h0; n_req = 0; n_xfer = 0;
    last_due = -1; prev_stall = 1'b0; w_prev_acc = 1'b0;
  endtask

  task automatic wait_xfer(input string name);
    int b;
    b = 0;
    do begin
      cycle();
      b++;
    end while (!xfer_s && b < 30);
    chk1({name, "_timeout"}, xfer_s, 1'b1);
  endtask

  function automatic vec_t mk(logic v, logic [31:0] pc, logic [15:0] imm, logic [25:0] idx,
                              logic z, logic [31:0] r, logic b, logic nb, logic j, logic jl,
                              logic jrr, logic er, logic [31:0] et);
    vec_t t;
    t.v = v; t.pc = pc; t.imm = imm; t.idx = idx; t.z = z; t.r = r;
    t.b = b; t.nb = nb; t.j = j; t.jl = jl; t.jrr = jrr;
    t.exp_redir = er; t.exp_target = et;
    return t;
  endfunction

  initial begin
    vec_t vt [11];
    logic [31:0] wexp [3];
    int b, rnd_x0;

    vt[0]  = mk(1, 32'h0000_0010, 16'hFFFC, 26'h0,       1, 32'h0,       1, 0, 0, 0, 0, 1, 32'h0000_0004);
    vt[1]  = mk(1, 32'h0000_0000, 16'h0,    26'h100,     0, 32'h400,     0, 0, 0, 1, 1, 1, 32'h0000_0400);
    vt[2]  = mk(1, 32'hF000_0000, 16'h0,    26'h3,       0, 32'h0,       0, 0, 1, 0, 0, 1, 32'hF000_000C);
    vt[3]  = mk(1, 32'h0000_0040, 16'h0010, 26'h0,       1, 32'h0,       0, 1, 0, 0, 0, 0, 32'h0);
    vt[4]  = mk(1, 32'h0000_0100, 16'h0010, 26'h0,       0, 32'h0,       0, 1, 0, 0, 0, 1, 32'h0000_0144);
    vt[5]  = mk(1, 32'h0000_0100, 16'h0010, 26'h0,       0, 32'h0,       1, 0, 0, 0, 0, 0, 32'h0);
    vt[6]  = mk(0, 32'h0000_0000, 16'h0,    26'h55,      1, 32'h800,     1, 0, 1, 0, 1, 0, 32'h0);
    vt[7]  = mk(1, 32'h0FFF_FFFC, 16'h0,    26'h3FF_FFFF, 0, 32'h0,      0, 0, 0, 1, 0, 1, 32'h1FFF_FFFC);
    vt[8]  = mk(1, 32'hFFFF_FFF8, 16'h0004, 26'h0,       1, 32'h0,       1, 0, 0, 0, 0, 1, 32'h0000_000C);
    vt[9]  = mk(1, 32'h0000_2000, 16'h0010, 26'h40,      1, 32'h0,       1, 0, 1, 0, 0, 1, 32'h0000_0100);
    vt[10] = mk(1, 32'h0000_3000, 16'h0010, 26'h40,      1, 32'h8000_0000, 1, 0, 0, 0, 1, 1, 32'h8000_0000);
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;

    lat = 1; req_ready = 1'b1; out_ready = 1'b1; cyc = 0;
    do_reset();

    // Linear stream: first instruction at cycle 2, then one per cycle.
    cycle(); chk1("lin_c0_idle", xfer_s, 1'b0);
    cycle(); chk1("lin_c1_idle", xfer_s, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk1("lin_xfer", xfer_s, 1'b1);
      chk32("lin_pc", xfer_pc, 32'(4 * k));
    end

    chk32("wrap_count", 32'(wrap_pcs.size()), 32'd3);
    for (int i = 0; i < wrap_pcs.size() && i < 3; i++) chk32("wrap_pc", wrap_pcs[i], wexp[i]);

    // Backpressure with a not-taken bne in the middle: queue fills to DEPTH and stays intact.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        ex_valid = 1'b1; nbr = 1'b1; zero = 1'b1; ex_pc = 32'h0000_0200; ex_imm = 16'h0008;
      end else begin
        clear_ex();
      end
      cycle();
    end
    clear_ex();
    chk1("bp_req_valid", req_valid, 1'b0);
    chk1("bp_out_valid", out_valid, 1'b1);
    chk32("bp_inflight", 32'(memq.size()), 32'd0);
    chk32("bp_queued", 32'(n_req - n_xfer), 32'(DEPTH));
    out_ready = 1'b1;
    repeat (8) cycle();

    // Taken beq with two requests in flight at latency 2.
    lat = 2;
    repeat (4) cycle();
    b = 0;
    while (memq.size() != 2 && b < 20) begin cycle(); b++; end
    chk32("disc_setup", 32'(memq.size()), 32'd2);
    ex_valid = 1'b1; br = 1'b1; zero = 1'b1; ex_pc = 32'h0000_0010; ex_imm = 16'hFFFC;
    cycle();
    clear_ex();
    chk1("disc_redirect", redir_s, 1'b1);
    wait_xfer("disc");
    chk32("disc_next_pc", xfer_pc, 32'h0000_0004);
    lat = 1;
    repeat (4) cycle();

    // Redirect vector table.
    for (int i = 0; i < 11; i++) begin
      ex_valid = vt[i].v; ex_pc = vt[i].pc; ex_imm = vt[i].imm; ex_index = vt[i].idx;
      zero = vt[i].z; rd1 = vt[i].r; br = vt[i].b; nbr = vt[i].nb; jmp = vt[i].j;
      jal = vt[i].jl; jr = vt[i].jrr;
      cycle();
      clear_ex();
      chk1("vec_redirect", redir_s, vt[i].exp_redir);
      if (vt[i].exp_redir) begin
        b = 0;
        do begin cycle(); b++; end while (!acc_s && b < 20);
        chk1("vec_req_timeout", acc_s, 1'b1);
        chk32("vec_target", acc_addr, vt[i].exp_target);
      end
      repeat (3) cycle();
    end

    // Asynchronous reset between edges with three entries queued.
    do_reset();
    out_ready = 1'b0;
    b = 0;
    while ((n_req - n_xfer - memq.size()) != 3 && b < 20) begin cycle(); b++; end
    chk32("mid_setup", 32'(n_req - n_xfer - memq.size()), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk1("mid_out_valid", out_valid, 1'b0);
    chk1("mid_req_valid", req_valid, 1'b0);
    do_reset();
    out_ready = 1'b1;
    cycle();
    chk1("mid_restart_req", acc_s, 1'b1);
    chk32("mid_restart_addr", acc_addr, 32'h0000_0000);
    repeat (5) cycle();

    // Randomized run against the stream model.
    rnd_x0 = n_xfer;
    for (int i = 0; i < 3000; i++) begin
      lat       = $urandom_range(1, 4);
      req_ready = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ex_valid  = ($urandom_range(0, 15) == 0);
      ex_pc     = $urandom() & 32'hFFFF_FFFC;
      ex_imm    = 16'($urandom());
      ex_index  = 26'($urandom());
      rd1       = $urandom() & 32'hFFFF_FFFC;
      zero      = ($urandom_range(0, 1) == 1);
      br        = ($urandom_range(0, 2) == 0);
      nbr       = ($urandom_range(0, 2) == 0);
      jmp       = ($urandom_range(0, 3) == 0);
      jal       = ($urandom_range(0, 3) == 0);
      jr        = ($urandom_range(0, 3) == 0);
      cycle();
    end
    clear_ex();
    chk1("rnd_progress", (n_xfer - rnd_x0) > 300, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
